// File: rtl/div_32b.sv
// ---------------------------------------------------------------------------
// div_32b : unsigned restoring shift-subtract divider, one quotient bit per
//           clock, MSB first.
//
// Ports
//   clk          in   clock, all state updates on the rising edge
//   rst_n        in   asynchronous active-low reset
//   start        in   request a division (ignored while busy)
//   a            in   WIDTH  unsigned dividend, sampled when start is accepted
//   b            in   WIDTH  unsigned divisor, sampled when start is accepted
//   busy         out  high while a division is running
//   done         out  one-cycle pulse, results valid in that cycle
//   quot         out  WIDTH  floor(a/b), all ones when b=0
//   rem          out  WIDTH  a - b*quot, equals a when b=0
//   div_by_zero  out  set when the completed operation had b=0
//
// Timing: a non-zero divisor spends WIDTH cycles in RUN, so done appears
// WIDTH+1 edges after the start request is presented (33 for WIDTH=32).
// A zero divisor skips RUN and reports on the very next cycle. A start
// presented during the done cycle is accepted back-to-back.
// ---------------------------------------------------------------------------
module div_32b #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quot,
   output logic [WIDTH-1:0] rem,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] dividend;   // shifts out dividend bits, shifts in quotient bits
   logic [WIDTH-1:0] divisor;
   logic [WIDTH-1:0] part_rem;   // restored remainder is always < divisor

   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   diff;
   logic             take;
   logic [WIDTH-1:0] rem_step;
   logic [WIDTH-1:0] dividend_step;
   logic             last;

   // 33-bit trial subtract. shifted < 2*divisor, so when shifted >= divisor
   // the difference fits in WIDTH bits; when shifted < divisor the result
   // wraps and its top bit is set. The top bit is therefore the borrow.
   assign shifted       = {part_rem, dividend[WIDTH-1]};
   assign diff          = shifted - {1'b0, divisor};
   assign take          = ~diff[WIDTH];
   assign rem_step      = take ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
   assign dividend_step = {dividend[WIDTH-2:0], take};
   assign last          = (count == CW'(WIDTH - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         count       <= '0;
         dividend    <= '0;
         divisor     <= '0;
         part_rem    <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         quot        <= '0;
         rem         <= '0;
         div_by_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  dividend    <= a;
                  divisor     <= b;
                  part_rem    <= '0;
                  count       <= '0;
                  div_by_zero <= 1'b0;
                  if (b == '0) begin
                     // Zero divisor: report immediately, no RUN cycles.
                     quot        <= '1;
                     rem         <= a;
                     div_by_zero <= 1'b1;
                     done        <= 1'b1;
                     busy        <= 1'b0;
                     state       <= DONE;
                  end else begin
                     busy  <= 1'b1;
                     state <= RUN;
                  end
               end else begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            RUN: begin
               part_rem <= rem_step;
               dividend <= dividend_step;
               count    <= count + 1'b1;
               if (last) begin
                  quot  <= dividend_step;
                  rem   <= rem_step;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_32b.sv
// ---------------------------------------------------------------------------
// tb_div_32b : directed and random checks of div_32b.
// ---------------------------------------------------------------------------
module tb_div_32b;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] quot;
   logic [31:0] rem;
   logic        div_by_zero;

   int passed = 0;
   int failed = 0;
   int total  = 0;

   div_32b #(.WIDTH(32)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .a           (a),
      .b           (b),
      .busy        (busy),
      .done        (done),
      .quot        (quot),
      .rem         (rem),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Presents start with (av, bv) for one edge and waits for done.
   // lat counts edges from the accepting edge (1) to the edge after which
   // done is seen; busy_cycles counts sampled cycles with busy high.
   // With b2b=1 the start is driven right away (caller is in a done cycle).
   task automatic do_op(input logic [31:0] av, input logic [31:0] bv, input bit b2b,
                        output int lat, output int busy_cycles);
      if (!b2b) @(negedge clk);
      a     = av;
      b     = bv;
      start = 1'b1;
      @(posedge clk);
      #1;
      start       = 1'b0;
      a           = 32'hDEAD_BEEF;   // operands must already be latched
      b           = 32'h0000_0003;
      lat         = 1;
      busy_cycles = busy ? 1 : 0;
      while (!done && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
         if (busy) busy_cycles++;
      end
   endtask

   initial begin
      int lat;
      int bcyc;
      bit seen;
      logic [63:0] prod;
      logic [31:0] ra;
      logic [31:0] rb;

      rst_n = 1'b0;
      start = 1'b0;
      a     = '0;
      b     = '0;

      // Reset state, before any clock edge
      #2;
      check("reset_busy", {31'b0, busy}, 32'd0);
      check("reset_done", {31'b0, done}, 32'd0);
      check("reset_quot", quot, 32'd0);
      check("reset_rem",  rem,  32'd0);
      check("reset_dbz",  {31'b0, div_by_zero}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // 100 / 7
      do_op(32'd100, 32'd7, 1'b0, lat, bcyc);
      $display("op a=100 b=7 lat=%0d busy=%0d quot=%0d rem=%0d dbz=%0b", lat, bcyc, quot, rem, div_by_zero);
      check("100/7_latency", lat, 32'd33);
      check("100/7_busy_cycles", bcyc, 32'd32);
      check("100/7_quot", quot, 32'd14);
      check("100/7_rem", rem, 32'd2);
      check("100/7_dbz", {31'b0, div_by_zero}, 32'd0);
      @(posedge clk);
      #1;
      check("100/7_done_one_cycle", {31'b0, done}, 32'd0);
      check("100/7_quot_hold", quot, 32'd14);

      // 5 / 0
      do_op(32'd5, 32'd0, 1'b0, lat, bcyc);
      $display("op a=5 b=0 lat=%0d busy=%0d quot=0x%08h rem=%0d dbz=%0b", lat, bcyc, quot, rem, div_by_zero);
      check("5/0_latency", lat, 32'd1);
      check("5/0_busy_cycles", bcyc, 32'd0);
      check("5/0_quot", quot, 32'hFFFF_FFFF);
      check("5/0_rem", rem, 32'd5);
      check("5/0_dbz", {31'b0, div_by_zero}, 32'd1);

      // 0xFFFFFFFF / 1
      do_op(32'hFFFF_FFFF, 32'd1, 1'b0, lat, bcyc);
      $display("op a=0xffffffff b=1 lat=%0d quot=0x%08h rem=%0d", lat, quot, rem);
      check("max/1_quot", quot, 32'hFFFF_FFFF);
      check("max/1_rem", rem, 32'd0);
      check("max/1_dbz", {31'b0, div_by_zero}, 32'd0);

      // 0xFFFFFFFF / 0xFFFFFFFF
      do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat, bcyc);
      $display("op a=0xffffffff b=0xffffffff lat=%0d quot=%0d rem=%0d", lat, quot, rem);
      check("max/max_quot", quot, 32'd1);
      check("max/max_rem", rem, 32'd0);

      // 0 / 9: a < b still takes the full latency
      do_op(32'd0, 32'd9, 1'b0, lat, bcyc);
      $display("op a=0 b=9 lat=%0d quot=%0d rem=%0d", lat, quot, rem);
      check("0/9_latency", lat, 32'd33);
      check("0/9_quot", quot, 32'd0);
      check("0/9_rem", rem, 32'd0);

      // 3 / 10 then back-to-back 1000 / 10 from the done cycle
      do_op(32'd3, 32'd10, 1'b0, lat, bcyc);
      $display("op a=3 b=10 lat=%0d quot=%0d rem=%0d", lat, quot, rem);
      check("3/10_latency", lat, 32'd33);
      check("3/10_quot", quot, 32'd0);
      check("3/10_rem", rem, 32'd3);
      do_op(32'd1000, 32'd10, 1'b1, lat, bcyc);
      $display("op a=1000 b=10 (back-to-back) lat=%0d quot=%0d rem=%0d", lat, quot, rem);
      check("b2b_latency", lat, 32'd33);
      check("b2b_quot", quot, 32'd100);
      check("b2b_rem", rem, 32'd0);

      // 1000 / 3 with an ignored start at cycle 10
      @(negedge clk);
      a     = 32'd1000;
      b     = 32'd3;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      lat   = 1;
      seen  = 1'b0;
      while (!done && lat < 100) begin
         if (lat == 5) check("run_quot_hold", quot, 32'd100);
         if (lat == 9) begin
            a     = 32'd9;
            b     = 32'd9;
            start = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(posedge clk);
         #1;
         lat++;
      end
      start = 1'b0;
      $display("op a=1000 b=3 (ignored start) lat=%0d quot=%0d rem=%0d", lat, quot, rem);
      check("ign_latency", lat, 32'd33);
      check("ign_quot", quot, 32'd333);
      check("ign_rem", rem, 32'd1);

      // Reset in the middle of RUN
      @(negedge clk);
      a     = 32'd1000;
      b     = 32'd3;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (14) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      $display("reset mid-run busy=%0b done=%0b quot=%0d rem=%0d dbz=%0b", busy, done, quot, rem, div_by_zero);
      check("midrst_busy", {31'b0, busy}, 32'd0);
      check("midrst_done", {31'b0, done}, 32'd0);
      check("midrst_quot", quot, 32'd0);
      check("midrst_rem", rem, 32'd0);
      check("midrst_dbz", {31'b0, div_by_zero}, 32'd0);
      seen = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
         if (done) seen = 1'b1;
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (25) begin
         @(posedge clk);
         #1;
         if (done) seen = 1'b1;
      end
      check("midrst_no_done", {31'b0, seen}, 32'd0);

      // First start after reset is accepted normally
      do_op(32'd100, 32'd7, 1'b0, lat, bcyc);
      $display("op a=100 b=7 (after reset) lat=%0d quot=%0d rem=%0d", lat, quot, rem);
      check("post_rst_latency", lat, 32'd33);
      check("post_rst_quot", quot, 32'd14);
      check("post_rst_rem", rem, 32'd2);

      // Random regression on the division identity
      for (int i = 0; i < 1000; i++) begin
         ra = $urandom;
         case (i % 3)
            0:       rb = $urandom;
            1:       rb = $urandom_range(1, 65535);
            default: rb = $urandom_range(1, 15);
         endcase
         if (rb == 32'd0) rb = 32'd1;
         do_op(ra, rb, 1'b0, lat, bcyc);
         prod = {32'b0, quot} * {32'b0, rb} + {32'b0, rem};
         $display("rnd %0d a=0x%08h b=0x%08h quot=0x%08h rem=0x%08h lat=%0d", i, ra, rb, quot, rem, lat);
         check("rnd_latency", lat, 32'd33);
         check("rnd_identity_hi", prod[63:32], 32'd0);
         check("rnd_identity_lo", prod[31:0], ra);
         check("rnd_rem_lt_b", {31'b0, (rem < rb)}, 32'd1);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/div_32b.md
DIV_32B -- requirements
Module: div_32b

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width; all requirements below are stated for WIDTH=32.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request a division; sampled on the rising edge of clk.
REQ-005 a  input  32  unsigned dividend; sampled on the edge where start is accepted.
REQ-006 b  input  32  unsigned divisor; sampled on the edge where start is accepted.
REQ-007 busy  output  1  high while a division is in progress; start is ignored while busy=1.
REQ-008 done  output  1  one-cycle pulse; quot, rem and div_by_zero are valid in that cycle.
REQ-009 quot  output  32  unsigned quotient floor(a/b).
REQ-010 rem  output  32  unsigned remainder a - b*quot.
REQ-011 div_by_zero  output  1  set when the completed operation had b=0.

Function
REQ-012 Unsigned restoring shift-subtract division, one quotient bit per clock, MSB first.
REQ-013 FSM states: IDLE, RUN, DONE; no other reachable states.
REQ-014 IDLE: busy=0, done=0; start=1 accepted -> latch a and b, clear div_by_zero; b!=0 -> RUN with step counter=0; b=0 -> DONE.
REQ-015 RUN: busy=1; each edge shifts {partial remainder, dividend} left by one bit.
REQ-016 RUN trial subtract: partial remainder >= divisor -> subtract and shift in quotient bit 1; otherwise keep and shift in 0.
REQ-017 Partial remainder datapath is 33 bits, so the trial subtract cannot overflow for any divisor up to 0xFFFFFFFF.
REQ-018 RUN lasts exactly 32 edges; the 32nd edge writes quot and rem and goes to DONE.
REQ-019 DONE: busy=0, done=1 for exactly one cycle; next edge -> IDLE, or accepts a new start (back-to-back, same rules as IDLE).
REQ-020 Latency, b!=0: start accepted at edge N -> done high in the cycle after edge N+33 (33 cycles start-to-done).
REQ-021 Latency, b=0: start accepted at edge N -> done high in the cycle after edge N+1.
REQ-022 b=0 results: quot=0xFFFFFFFF, rem=a, div_by_zero=1; no RUN cycles.
REQ-023 quot, rem and div_by_zero hold their last values until the next completion or reset; they do not change during RUN.
REQ-024 start=1 while busy=1 is ignored, with no effect on state, counter or operands.
REQ-025 Changes on a and b after start is accepted do not affect the result.
REQ-026 a < b (including a=0, b!=0) -> quot=0, rem=a after the full 33-cycle latency; there is no early termination.

Reset
REQ-027 rst_n=0 -> immediately, independent of clk: state=IDLE, busy=0, done=0, quot=0, rem=0, div_by_zero=0, step counter=0, internal operand registers=0.
REQ-028 Reset asserted mid-RUN or in DONE aborts the operation; no done pulse is produced for it.
REQ-029 After reset deassertion, the first rising edge with start=1 is accepted normally.

Verification
REQ-030 a=100, b=7, start for 1 cycle -> busy=1 for 32 cycles, done in cycle 33, quot=14, rem=2, div_by_zero=0.
REQ-031 a=5, b=0 -> done in cycle 1, quot=0xFFFFFFFF, rem=5, div_by_zero=1, busy never high.
REQ-032 a=0xFFFFFFFF, b=1 -> quot=0xFFFFFFFF, rem=0.
REQ-033 a=0xFFFFFFFF, b=0xFFFFFFFF -> quot=1, rem=0.
REQ-034 a=3, b=10 -> quot=0, rem=3; then start(a=1000, b=10) in the DONE cycle -> accepted back-to-back, quot=100, rem=0.
REQ-035 a=1000, b=3 started; start(a=9, b=9) at cycle 10 -> ignored, result quot=333, rem=1; a separate run with rst_n pulsed low at cycle 15 -> all outputs 0 immediately, no done pulse.
REQ-036 Random regression: 1000 random (a, b) pairs, b!=0 -> quot*b + rem == a and rem < b on every done pulse.
